fp_add_arbiter: RTL

//  Shares one parameterized_adder among NUM_REQ requesters with per-port valid/ready handshakes.

---
 rtl/tpu_arith_pkg.sv | 30 +++
 rtl/parameterized_adder.sv | 78 +++++++
 rtl/rr_arbiter.sv | 21 ++
 rtl/fp_add_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/tpu_arith_pkg.sv
// Shared arithmetic constants, requester tag type and the round-robin pick helper
// used by the shared-adder arbiter.
package tpu_arith_pkg;
    localparam int MAX_REQ = 8;
    localparam int TAG_W   = 3;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF800000;

    typedef logic [TAG_W-1:0] tag_t;

    // First set bit of valid at or after ptr, scanning modulo n.
    function automatic tag_t rr_pick(input logic [MAX_REQ-1:0] valid, input tag_t ptr, input int n);
        tag_t idx;
        logic hit;
        int   j;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (!hit && k < n && valid[j[2:0]]) begin
                idx = tag_t'(j);
                hit = 1'b1;
            end
        end
        return idx;
    endfunction
endpackage

// File: rtl/parameterized_adder.sv
// Combinational adder: IEEE-754 single (RNE, denormals flushed) or saturating
// two's-complement fixed point.
module parameterized_adder
    import tpu_arith_pkg::*;
#(
    parameter     FORMAT    = "FP32",
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16,
    parameter int WIDTH     = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    if (FORMAT == "FP32") begin : g_fp32
        logic [31:0]       x, z;
        logic [7:0]        ex, ez, d;
        logic [26:0]       mx, mz, sh, nrm;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic [24:0]       mr;
        logic              nan, hit, rup;

        always_comb begin
            if (a[30:0] >= b[30:0]) begin x = a; z = b; end
            else                    begin x = b; z = a; end
            ex  = x[30:23];
            ez  = z[30:23];
            nan = (ex == 8'hFF && x[22:0] != '0) || (ez == 8'hFF && z[22:0] != '0) ||
                  (ex == 8'hFF && ez == 8'hFF && x[31] != z[31]);
            mx  = (ex == 8'h00) ? '0 : {1'b1, x[22:0], 3'b000};
            mz  = (ez == 8'h00) ? '0 : {1'b1, z[22:0], 3'b000};
            d   = ex - ez;
            // Alignment keeps guard/round bits and folds everything shifted out into sticky.
            if (d >= 8'd27) sh = {26'b0, |mz};
            else            sh = (mz >> d) | {26'b0, |(mz & ~(27'h7FFFFFF << d))};
            sum = (x[31] == z[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
            e   = {2'b00, ex};
            lz  = '0;
            hit = 1'b0;
            nrm = '0;
            if (sum[27]) begin
                nrm = sum[27:1] | {26'b0, sum[0]};
                e   = e + 10'sd1;
            end else begin
                for (int i = 26; i >= 0; i--) begin
                    if (!hit && sum[i]) begin
                        lz  = 5'(26 - i);
                        hit = 1'b1;
                    end
                end
                nrm = sum[26:0] << lz;
                e   = e - {5'b0, lz};
            end
            rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
            mr  = {1'b0, nrm[26:3]} + {24'b0, rup};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 10'sd1;
            end
            if (nan)                 y = FP_QNAN;
            else if (ex == 8'hFF)    y = x[31] ? FP_NEG_INF : FP_POS_INF;
            else if (sum == '0)      y = {x[31] & z[31], 31'b0};
            else if (e >= 10'sd255)  y = {x[31], 8'hFF, 23'b0};
            else if (e <= 10'sd0)    y = {x[31], 31'b0};
            else                     y = {x[31], e[7:0], mr[22:0]};
        end
    end else begin : g_fixed
        logic [WIDTH:0] s;

        always_comb begin
            s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            if (s[WIDTH] != s[WIDTH-1]) y = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else                        y = s[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index, starting at ptr.
module rr_arbiter
    import tpu_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  tag_t         ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output tag_t         gnt_idx
);
    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        gnt_idx        = rr_pick(req_ext, ptr, N);
        gnt            = (en && |req) ? (N'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one adder among NUM_REQ requesters:
// grant -> S1 operand register -> adder -> S2 result register -> owning requester.
module fp_add_arbiter
    import tpu_arith_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter     FORMAT    = "FP32",
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16,
    parameter int WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]              rsp_result,
    output logic                          busy
);
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, res2_q, res2_d;
    tag_t             tag1_q, tag1_d, tag2_q, tag2_d, ptr_q, ptr_d;
    logic             s2_free, s1_adv, s1_free, accept;
    logic [NUM_REQ-1:0] gnt;
    tag_t             gnt_idx;
    logic [WIDTH-1:0] a_sel, b_sel, add_y;

    assign rsp_valid  = v2_q ? (NUM_REQ'(1) << tag2_q) : '0;
    assign rsp_result = res2_q;
    assign busy       = v1_q | v2_q;
    // Only the ready of the port that owns S2 can drain it.
    assign s2_free    = !v2_q || |(rsp_valid & rsp_ready);
    assign s1_adv     = v1_q & s2_free;
    assign s1_free    = !v1_q || s1_adv;
    assign req_ready  = gnt;
    assign accept     = |gnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (s1_free & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    parameterized_adder #(
        .FORMAT    (FORMAT),
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS),
        .WIDTH     (WIDTH)
    ) u_add (
        .a (a1_q),
        .b (b1_q),
        .y (add_y)
    );

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i];
                b_sel = req_b[i];
            end
        end
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        tag1_d = tag1_q;
        ptr_d  = ptr_q;
        v2_d   = v2_q;
        res2_d = res2_q;
        tag2_d = tag2_q;
        if (s1_adv) begin
            v2_d   = 1'b1;
            res2_d = add_y;
            tag2_d = tag1_q;
            v1_d   = 1'b0;
        end else if (s2_free) begin
            v2_d = 1'b0;
        end
        if (accept) begin
            v1_d   = 1'b1;
            a1_d   = a_sel;
            b1_d   = b_sel;
            tag1_d = gnt_idx;
            ptr_d  = (gnt_idx == tag_t'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            tag1_q <= '0;
            ptr_q  <= '0;
            v2_q   <= 1'b0;
            res2_q <= '0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            tag1_q <= tag1_d;
            ptr_q  <= ptr_d;
            v2_q   <= v2_d;
            res2_q <= res2_d;
            tag2_q <= tag2_d;
        end
    end
endmodule
